// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with hardware call/return LIFO stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 8,
    parameter int INC       = 1,
    parameter int RESET_VEC = 0
) (
    input  logic                       clk,
    input  logic                       init,
    input  logic                       wrpc,
    input  logic                       jump,
    input  logic                       prefix,
    input  logic                       ch,
    input  logic                       ret,
    input  logic                       rst,
    input  logic                       hlt,
    input  logic [ADDR_W-1:0]          imm,
    input  logic [ADDR_W-1:0]          rs_val,
    output logic [ADDR_W-1:0]          pc,
    output logic [ADDR_W-1:0]          ret_top,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       empty,
    output logic                       full,
    output logic                       err_ovf,
    output logic                       err_unf
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [ADDR_W-1:0] c_reset_vec = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] c_inc       = ADDR_W'(INC);
    localparam logic [SP_W-1:0]   c_depth     = SP_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic              r_err_ovf;
    logic              r_err_unf;
    logic [ADDR_W-1:0] r_stack [DEPTH];

    logic              w_active;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_top;

    assign w_active  = !rst && !hlt;
    assign w_pop     = wrpc && ret;
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == c_depth);
    assign w_top_idx = IDX_W'(r_sp - 1'b1);
    assign w_target  = prefix ? imm : rs_val;
    assign w_top     = r_stack[w_top_idx];

    // A push that coincides with a successful pop overwrites the popped slot (swap).
    assign w_wr_idx = (w_pop && !w_empty) ? w_top_idx : IDX_W'(r_sp);
    assign w_wr_en  = w_active && ch && ((w_pop && !w_empty) || !w_full);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_pc      <= c_reset_vec;
            r_sp      <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (rst) begin
            r_pc      <= c_reset_vec;
            r_sp      <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (!hlt) begin
            if (w_pop) begin
                if (!w_empty) begin
                    r_pc <= w_top;
                    if (!ch) begin
                        r_sp <= r_sp - 1'b1;
                    end
                end else begin
                    r_pc      <= c_reset_vec;
                    r_err_unf <= 1'b1;
                    if (ch) begin
                        r_sp <= r_sp + 1'b1;
                    end
                end
            end else begin
                if (wrpc) begin
                    r_pc <= jump ? w_target : (r_pc + c_inc);
                end
                if (ch) begin
                    if (w_full) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        r_sp <= r_sp + 1'b1;
                    end
                end
            end
        end
    end

    // Stack contents are don't-care after reset, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stack[w_wr_idx] <= r_pc;
        end
    end

    assign pc      = r_pc;
    assign ret_top = w_empty ? '0 : w_top;
    assign sp      = r_sp;
    assign empty   = w_empty;
    assign full    = w_full;
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Program-counter and hardware call/return-stack block that sits directly downstream of the control unit. It consumes `wrpc`, `jump`, `prefix`, `ch`, `ret`, `rst` and `hlt` and produces the instruction fetch address `pc`. It also holds the return addresses for `ch`/`ret` in an internal LIFO, which replaces the former ALU-based PC increment path.

## Interface
- `ADDR_W`, 16: PC and target width.
- `DEPTH`, 8: return-stack entries; must be a power of two, at least 2.
- `INC`, 1: sequential PC increment.
- `RESET_VEC`, 0: PC value after reset or soft reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `init`  in  1  reset. Reset is asynchronous and active-high: one clock; reset is asynchronous and active-high.
- `wrpc`  in  1  PC write enable.
- `jump`  in  1  select branch target instead of increment.
- `prefix`  in  1  target source: 1 = `imm`, 0 = `rs_val`.
- `ch`  in  1  call: push return address.
- `ret`  in  1  return: pop on `wrpc`.
- `rst`  in  1  synchronous soft reset from the control unit.
- `hlt`  in  1  freeze PC and stack.
- `imm`  in  ADDR_W  immediate branch target.
- `rs_val`  in  ADDR_W  register branch target.
- `pc`  out  ADDR_W  current fetch address.
- `ret_top`  out  ADDR_W  top stack entry; 0 when empty.
- `sp`  out  $clog2(DEPTH)+1  number of valid entries.
- `empty`  out  1  `sp == 0`.
- `full`  out  1  `sp == DEPTH`.
- `err_ovf`  out  1  sticky: push attempted while full.
- `err_unf`  out  1  sticky: pop attempted while empty.

## Operation
- Registers: `pc`, stack array, `sp`, `err_ovf`, `err_unf`. All outputs are registered or decoded from registers; no input-to-output combinational path.
- `target = prefix ? imm : rs_val`.
- Per-edge priority, highest first:
  1. `init` (async): `pc = RESET_VEC`, `sp = 0`, both error flags 0, stack contents don't-care.
  2. `rst`: same effect as `init`, applied synchronously on the edge; all other inputs are ignored that cycle.
  3. `hlt`: nothing changes, regardless of the other inputs.
  4. Pop, when `wrpc & ret`:
     - not empty: `pc <= stack[sp-1]`, `sp <= sp-1`.
     - empty: `pc <= RESET_VEC`, `err_unf <= 1`.
  5. When `wrpc & jump & !ret`: `pc <= target`.
  6. When `wrpc & !jump & !ret`: `pc <= pc + INC`, modulo 2^ADDR_W (0xFFFF+1 wraps to 0).
- Push, when `ch` is high and `rst`/`hlt` are not (evaluated alongside steps 4–6):
  - not full: `stack[sp] <= pc`, `sp <= sp+1`. The value pushed is the `pc` register before this edge's update.
  - full: push discarded, `sp` unchanged, `err_ovf <= 1`.
- `ch` high for N cycles pushes N entries. The control unit drives `ch` for exactly one cycle.
- Simultaneous push and pop (`ch & wrpc & ret`):
  - not empty: swap. `pc <= old top`, `stack[sp-1] <= old pc`, `sp` unchanged.
  - empty: the pop underflows as in step 4 and the push proceeds normally.
- `ch` with `wrpc & jump` on the same edge: push the old `pc`, load `target`.
- Error flags clear only on `init` or `rst`.

## Timing
- All updates take effect on the rising `clk` edge where the controls are sampled and are visible on outputs in the following cycle. Latency is 1 cycle.
- Normal call sequence: `ch` at cycle T pushes; `wrpc & jump` at T+2 loads `target`; the new `pc` is visible at T+3.
- Normal return sequence: `ret` and `jump` at T, `wrpc & ret` at T+1 pops; the popped `pc` is visible at T+2.
- `init` asserted mid-cycle forces outputs to reset values immediately, without waiting for a clock. Deassertion is synchronised externally.
- Reset values: `pc = RESET_VEC`, `ret_top = 0`, `sp = 0`, `empty = 1`, `full = 0`, `err_ovf = 0`, `err_unf = 0`.

## Test plan
- Reset and increment: pulse `init`, then `wrpc=1` for 3 cycles with `jump=0` → `pc` = 0, 1, 2, 3. Preload `pc = 0xFFFF`, one increment → `pc = 0`.
- Jump sources: `wrpc=jump=prefix=1`, `imm=0x1234` → `pc = 0x1234`. Then `prefix=0`, `rs_val=0x00A0` → `pc = 0x00A0`. With `hlt=1` during a third jump → `pc` stays 0x00A0.
- Nested call/return: at `pc=0x10` call `0x200`, at `pc=0x200` call `0x300`, then two returns → `pc` = 0x200 then 0x10, `sp` = 2→1→0, `empty=1`.
- Overflow and underflow: 9 pushes with `DEPTH=8` → `full=1`, `sp=8`, `err_ovf=1`, top equals the 8th pushed value. Then 9 pops → the 9th pop gives `pc=RESET_VEC` and `err_unf=1`.
- Swap: `sp=1`, top=0x40, `pc=0x80`, assert `ch`, `wrpc`, `ret` together → `pc=0x40`, `ret_top=0x80`, `sp=1`.
- Soft reset mid-operation: `sp=3`, `err_ovf=1`, `rst=1` with `wrpc & jump` also asserted → `pc=RESET_VEC`, `sp=0`, flags 0, jump ignored. Asynchronous `init` between edges → outputs reset before the next edge.
